// File: rtl/cond_eval_pipe.sv
// Two-stage valid/ready branch-condition evaluator with a persistent compare-flag register.
// Optional build macro COND_STATS_EN adds saturating taken/evaluated result counters.
module cond_eval_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       cond,
    input  logic             sgn,
    input  logic             use_flags,
    input  logic [WIDTH-1:0] ARG1,
    input  logic [WIDTH-1:0] _ARG2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Output,
    output logic [2:0]       flags
`ifdef COND_STATS_EN
    ,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] eval_cnt
`endif
);

    typedef enum logic [2:0] {
        CC_EQ     = 3'd0,
        CC_NE     = 3'd1,
        CC_LT     = 3'd2,
        CC_LE     = 3'd3,
        CC_GT     = 3'd4,
        CC_GE     = 3'd5,
        CC_ALWAYS = 3'd6,
        CC_NEVER  = 3'd7
    } cond_code_t;

    // Degenerate widths would make the signed compare meaningless.
    if (WIDTH < 2 || CNT_W < 1) begin : g_bad_params
    end

    logic             s1_valid_reg;
    cond_code_t       s1_cond_reg;
    logic             s1_sgn_reg;
    logic             s1_use_flags_reg;
    logic [WIDTH-1:0] s1_arg1_reg;
    logic [WIDTH-1:0] s1_arg2_reg;
    logic             s2_valid_reg;
    logic             s2_result_reg;
    logic [2:0]       flags_reg;

    logic s2_adv;
    logic s1_adv;
    logic accept;
    logic eq_cmp, ltu_cmp, lts_cmp;
    logic eq_sel, lt_sel;
    logic result_next;

    assign s2_adv   = !s2_valid_reg || out_ready;
    assign s1_adv   = s1_valid_reg && s2_adv;
    assign in_ready = !s1_valid_reg || s2_adv;
    assign accept   = in_valid && in_ready;

    always_comb begin
        eq_cmp  = (s1_arg1_reg == s1_arg2_reg);
        ltu_cmp = (s1_arg1_reg < s1_arg2_reg);
        lts_cmp = ($signed(s1_arg1_reg) < $signed(s1_arg2_reg));
        eq_sel  = eq_cmp;
        lt_sel  = s1_sgn_reg ? lts_cmp : ltu_cmp;
        // Flag-mode ops reuse the stored {LTS, LTU, EQ} of the previous compare.
        if (s1_use_flags_reg) begin
            eq_sel = flags_reg[0];
            lt_sel = s1_sgn_reg ? flags_reg[2] : flags_reg[1];
        end
        result_next = 1'b0;
        case (s1_cond_reg)
            CC_EQ:     result_next = eq_sel;
            CC_NE:     result_next = !eq_sel;
            CC_LT:     result_next = lt_sel;
            CC_LE:     result_next = lt_sel || eq_sel;
            CC_GT:     result_next = !(lt_sel || eq_sel);
            CC_GE:     result_next = !lt_sel;
            CC_ALWAYS: result_next = 1'b1;
            CC_NEVER:  result_next = 1'b0;
            default:   result_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg     <= 1'b0;
            s1_cond_reg      <= CC_EQ;
            s1_sgn_reg       <= 1'b0;
            s1_use_flags_reg <= 1'b0;
            s1_arg1_reg      <= '0;
            s1_arg2_reg      <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (accept) begin
                s1_cond_reg      <= cond_code_t'(cond);
                s1_sgn_reg       <= sgn;
                s1_use_flags_reg <= use_flags;
                s1_arg1_reg      <= ARG1;
                s1_arg2_reg      <= _ARG2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg  <= 1'b0;
            s2_result_reg <= 1'b0;
            flags_reg     <= 3'b000;
        end else begin
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
            end
            if (s1_adv) begin
                s2_result_reg <= result_next;
                if (!s1_use_flags_reg) begin
                    flags_reg <= {lts_cmp, ltu_cmp, eq_cmp};
                end
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign Output    = s2_result_reg;
    assign flags     = flags_reg;

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] taken_cnt_reg;
    logic [CNT_W-1:0] eval_cnt_reg;
    logic             deliver;

    assign deliver = s2_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            taken_cnt_reg <= '0;
            eval_cnt_reg  <= '0;
        end else if (deliver) begin
            if (eval_cnt_reg != {CNT_W{1'b1}}) begin
                eval_cnt_reg <= eval_cnt_reg + CNT_W'(1);
            end
            if (s2_result_reg && (taken_cnt_reg != {CNT_W{1'b1}})) begin
                taken_cnt_reg <= taken_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign taken_cnt = taken_cnt_reg;
    assign eval_cnt  = eval_cnt_reg;
`endif

endmodule
